// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Covers FSM states, ALU/cmd/cond codes, mux-select encodings and the data-processing decode helper.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, ALUWB, BRANCH, MULEX, MULWB
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_EOR   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_MUL    = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic [2:0] alu;
        logic       no_write;
        logic       flag_nz;
        logic       flag_cv;
    } dp_decode_t;

    // Compare/test ops always update flags and never write a register; unknown cmds do neither.
    function automatic dp_decode_t decode_cmd(input logic [3:0] cmd, input logic s);
        dp_decode_t d;
        d.alu      = ALU_ADD;
        d.no_write = 1'b1;
        d.flag_nz  = 1'b0;
        d.flag_cv  = 1'b0;
        case (cmd)
            CMD_ADD: begin d.alu = ALU_ADD;   d.no_write = 1'b0; d.flag_nz = s;    d.flag_cv = s;    end
            CMD_CMN: begin d.alu = ALU_ADD;   d.no_write = 1'b1; d.flag_nz = 1'b1; d.flag_cv = 1'b1; end
            CMD_SUB: begin d.alu = ALU_SUB;   d.no_write = 1'b0; d.flag_nz = s;    d.flag_cv = s;    end
            CMD_CMP: begin d.alu = ALU_SUB;   d.no_write = 1'b1; d.flag_nz = 1'b1; d.flag_cv = 1'b1; end
            CMD_AND: begin d.alu = ALU_AND;   d.no_write = 1'b0; d.flag_nz = s;    end
            CMD_TST: begin d.alu = ALU_AND;   d.no_write = 1'b1; d.flag_nz = 1'b1; end
            CMD_ORR: begin d.alu = ALU_ORR;   d.no_write = 1'b0; d.flag_nz = s;    end
            CMD_EOR: begin d.alu = ALU_EOR;   d.no_write = 1'b0; d.flag_nz = s;    end
            CMD_MOV: begin d.alu = ALU_PASSB; d.no_write = 1'b0; d.flag_nz = s;    end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and control outputs exchanged between the datapath and the control unit.
interface multicycle_ctrl_if #(
    parameter int ALUCTRL_W = 3
);
    logic [3:0]           Cond;
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic                 Mul;
    logic [3:0]           ALUFlags;

    logic                 PCWrite;
    logic                 RegWrite;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 AdrSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ResultSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic                 MulBusy;
    logic [3:0]           Flags;

    modport master (
        output Cond, Op, Funct, Rd, Mul, ALUFlags,
        input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ALUControl, ImmSrc, RegSrc, MulBusy, Flags
    );

    modport slave (
        input  Cond, Op, Funct, Rd, Mul, ALUFlags,
        output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ALUControl, ImmSrc, RegSrc, MulBusy, Flags
    );
endinterface

// File: rtl/multicycle_ctrl_cond_unit.sv
// Condition unit: evaluates the ARM condition field against the NZCV register
// and holds that register, with separate write enables for NZ and CV.
module cond_unit
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       write_nz,
    input  logic       write_cv,
    output logic       cond_ex,
    output logic [3:0] flags
);
    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            flags <= 4'b0000;
        end else begin
            if (write_nz) flags[3:2] <= alu_flags[3:2];
            if (write_cv) flags[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM with variable-latency multiply, data-processing decode
// and condition unit. Write enables are forced low while Reset is asserted.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int MUL_LAT   = 4
) (
    input logic              clk,
    input logic              Reset,
    multicycle_ctrl_if.slave bus
);
    localparam int              CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] mul_cnt;
    logic [3:0]       rd_q;
    logic             no_write_q;
    dp_decode_t       dp;
    logic             cond_ex;
    logic [3:0]       flags;
    logic             exec_state;

    logic             pc_write_raw, reg_write_raw, mem_write_raw, ir_write_raw;
    logic             adr_src, alu_src_a, mul_busy;
    logic [1:0]       alu_src_b, result_src;
    logic [2:0]       alu_code;

    assign dp         = decode_cmd(bus.Funct[4:1], bus.Funct[0]);
    assign exec_state = (state_q == EXECR) || (state_q == EXECI);

    cond_unit u_cond (
        .clk       (clk),
        .Reset     (Reset),
        .cond      (bus.Cond),
        .alu_flags (bus.ALUFlags),
        .write_nz  (exec_state && dp.flag_nz),
        .write_cv  (exec_state && dp.flag_cv),
        .cond_ex   (cond_ex),
        .flags     (flags)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Rd is captured in DECODE so writeback decisions use the instruction's own destination.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            mul_cnt    <= '0;
            rd_q       <= 4'd0;
            no_write_q <= 1'b0;
        end else begin
            if (state_q == DECODE) rd_q <= bus.Rd;
            if (exec_state) no_write_q <= dp.no_write;
            if (state_q == DECODE && state_d == MULEX)
                mul_cnt <= MUL_LOAD;
            else if (state_q == MULEX && mul_cnt != '0)
                mul_cnt <= mul_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        result_src    = RES_ALUOUT;
        alu_code      = ALU_ADD;
        mul_busy      = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                state_d      = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (!cond_ex) begin
                    state_d = FETCH;
                end else begin
                    case (bus.Op)
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        2'b00: begin
                            if (bus.Mul)           state_d = MULEX;
                            else if (bus.Funct[5]) state_d = EXECI;
                            else                   state_d = EXECR;
                        end
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
                state_d   = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
                pc_write_raw  = (rd_q == 4'd15);
                state_d       = FETCH;
            end
            MEMWR: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = FETCH;
            end
            EXECR: begin
                alu_code = dp.alu;
                state_d  = ALUWB;
            end
            EXECI: begin
                alu_src_b = SRCB_IMM;
                alu_code  = dp.alu;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = !no_write_q;
                pc_write_raw  = !no_write_q && (rd_q == 4'd15);
                state_d       = FETCH;
            end
            MULEX: begin
                mul_busy = 1'b1;
                if (mul_cnt == '0) state_d = MULWB;
            end
            MULWB: begin
                result_src    = RES_MUL;
                reg_write_raw = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                alu_src_b    = SRCB_IMM;
                result_src   = RES_ALU;
                pc_write_raw = 1'b1;
                state_d      = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.PCWrite    = pc_write_raw && Reset;
    assign bus.RegWrite   = reg_write_raw && Reset;
    assign bus.MemWrite   = mem_write_raw && Reset;
    assign bus.IRWrite    = ir_write_raw && Reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = ALUCTRL_W'(alu_code);
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.MulBusy    = mul_busy;
    assign bus.Flags      = flags;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: random instruction stream against an instruction-level reference model,
// plus directed reset and multiply-latency scenarios.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_main;
    logic rst_mul;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.ALUCTRL_W(3)) mif ();
    multicycle_ctrl_if #(.ALUCTRL_W(3)) mif1 ();
    multicycle_ctrl_if #(.ALUCTRL_W(3)) mif7 ();

    multicycle_ctrl #(.ALUCTRL_W(3), .MUL_LAT(4)) dut (.clk(clk), .Reset(rst_main), .bus(mif.slave));
    multicycle_ctrl #(.ALUCTRL_W(3), .MUL_LAT(1)) dut1 (.clk(clk), .Reset(rst_mul), .bus(mif1.slave));
    multicycle_ctrl #(.ALUCTRL_W(3), .MUL_LAT(7)) dut7 (.clk(clk), .Reset(rst_mul), .bus(mif7.slave));

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
        P_EXECR, P_EXECI, P_ALUWB, P_MULEX, P_MULWB, P_BRANCH
    } phase_t;

    localparam logic [13:0] M_EN   = 14'h3C01;
    localparam logic [13:0] M_ADR  = 14'h0200;
    localparam logic [13:0] M_SRCA = 14'h0100;
    localparam logic [13:0] M_SRCB = 14'h00C0;
    localparam logic [13:0] M_RES  = 14'h0030;
    localparam logic [13:0] M_ALU  = 14'h000E;
    localparam logic [3:0]  AL     = 4'hE;
    localparam int          MAIN_LAT = 4;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] model_flags;

    logic [13:0] obs_main;
    logic [3:0]  obs1, obs7;

    assign obs_main = {mif.IRWrite, mif.PCWrite, mif.RegWrite, mif.MemWrite, mif.AdrSrc,
                       mif.ALUSrcA, mif.ALUSrcB, mif.ResultSrc, mif.ALUControl, mif.MulBusy};
    assign obs1 = {mif1.MulBusy, mif1.ResultSrc, mif1.RegWrite};
    assign obs7 = {mif7.MulBusy, mif7.ResultSrc, mif7.RegWrite};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [13:0] pack(input bit ir, input bit pc, input bit rw, input bit mw,
                                         input bit adr, input bit srca, input logic [1:0] srcb,
                                         input logic [1:0] res, input logic [2:0] alu, input bit mb);
        return {ir, pc, rw, mw, adr, srca, srcb, res, alu, mb};
    endfunction

    function automatic bit condHolds(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference table for data-processing commands: ALU op, suppressed writeback, flag bits updated.
    task automatic dpModel(input logic [3:0] cmd, input bit s, output logic [2:0] alu,
                           output bit nw, output logic [3:0] fm);
        logic [3:0] arith, logic_nz;
        arith    = s ? 4'b1111 : 4'b0000;
        logic_nz = s ? 4'b1100 : 4'b0000;
        case (cmd)
            4'b0100: begin alu = 3'd0; nw = 0; fm = arith;    end
            4'b1011: begin alu = 3'd0; nw = 1; fm = 4'b1111;  end
            4'b0010: begin alu = 3'd1; nw = 0; fm = arith;    end
            4'b1010: begin alu = 3'd1; nw = 1; fm = 4'b1111;  end
            4'b0000: begin alu = 3'd2; nw = 0; fm = logic_nz; end
            4'b1000: begin alu = 3'd2; nw = 1; fm = 4'b1100;  end
            4'b1100: begin alu = 3'd3; nw = 0; fm = logic_nz; end
            4'b0001: begin alu = 3'd4; nw = 0; fm = logic_nz; end
            4'b1101: begin alu = 3'd5; nw = 0; fm = logic_nz; end
            default: begin alu = 3'd0; nw = 1; fm = 4'b0000;  end
        endcase
    endtask

    task automatic expectPhase(input phase_t p, input logic [3:0] rd, input bit nw, input logic [2:0] alu,
                               output logic [13:0] exp, output logic [13:0] mask);
        bit pc15;
        pc15 = (rd == 4'd15);
        case (p)
            P_FETCH:  begin exp = pack(1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 3'd0, 0); mask = 14'h3FFF; end
            P_DECODE: begin exp = pack(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 3'd0, 0); mask = M_EN | M_SRCA | M_SRCB | M_RES; end
            P_MEMADR: begin exp = pack(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'd0, 0); mask = M_EN | M_SRCA | M_SRCB | M_ALU; end
            P_MEMRD:  begin exp = pack(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'd0, 0); mask = M_EN | M_ADR | M_RES; end
            P_MEMWB:  begin exp = pack(0, pc15, 1, 0, 0, 0, 2'b00, 2'b01, 3'd0, 0); mask = M_EN | M_RES; end
            P_MEMWR:  begin exp = pack(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'd0, 0); mask = M_EN | M_ADR; end
            P_EXECR:  begin exp = pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, alu, 0); mask = M_EN | M_SRCA | M_SRCB | M_ALU; end
            P_EXECI:  begin exp = pack(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, alu, 0); mask = M_EN | M_SRCA | M_SRCB | M_ALU; end
            P_ALUWB:  begin exp = pack(0, !nw && pc15, !nw, 0, 0, 0, 2'b00, 2'b00, 3'd0, 0); mask = M_EN | M_RES; end
            P_MULEX:  begin exp = pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'd0, 1); mask = M_EN; end
            P_MULWB:  begin exp = pack(0, 0, 1, 0, 0, 0, 2'b00, 2'b11, 3'd0, 0); mask = M_EN | M_RES; end
            default:  begin exp = pack(0, 1, 0, 0, 0, 0, 2'b01, 2'b10, 3'd0, 0); mask = M_EN | M_SRCA | M_SRCB | M_RES; end
        endcase
        exp = exp & mask;
    endtask

    // Called at a falling edge inside FETCH; returns at the falling edge inside the next FETCH.
    task automatic applyStimulus(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                                 input logic [3:0] rd, input logic mul, input logic [3:0] exec_flags,
                                 input string name);
        phase_t      ph[$];
        logic [2:0]  alu;
        bit          nw;
        logic [3:0]  fm;
        logic [13:0] exp, mask;
        bit          is_exec;
        mif.Cond  = cond;
        mif.Op    = op;
        mif.Funct = funct;
        mif.Rd    = rd;
        mif.Mul   = mul;
        dpModel(funct[4:1], funct[0], alu, nw, fm);
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        if (condHolds(cond, model_flags)) begin
            if (op == 2'b01) begin
                ph.push_back(P_MEMADR);
                if (funct[0]) begin ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
                else ph.push_back(P_MEMWR);
            end else if (op == 2'b10) begin
                ph.push_back(P_BRANCH);
            end else if (op == 2'b00 && mul) begin
                repeat (MAIN_LAT) ph.push_back(P_MULEX);
                ph.push_back(P_MULWB);
            end else if (op == 2'b00) begin
                ph.push_back(funct[5] ? P_EXECI : P_EXECR);
                ph.push_back(P_ALUWB);
            end
        end
        foreach (ph[k]) begin
            is_exec = (ph[k] == P_EXECR) || (ph[k] == P_EXECI);
            mif.ALUFlags = is_exec ? exec_flags : 4'($urandom);
            #1;
            expectPhase(ph[k], rd, nw, alu, exp, mask);
            checkOutput($sformatf("%s.%s", name, ph[k].name()), 32'(obs_main & mask), 32'(exp));
            checkOutput($sformatf("%s.flags", name), 32'(mif.Flags), 32'(model_flags));
            if (ph[k] == P_DECODE)
                checkOutput($sformatf("%s.imm_reg_src", name), 32'({mif.ImmSrc, mif.RegSrc}),
                            32'({op, op == 2'b01, op == 2'b10}));
            if (is_exec) model_flags = (model_flags & ~fm) | (exec_flags & fm);
            @(negedge clk);
        end
    endtask

    task automatic resetMidMul();
        mif.Cond  = AL;
        mif.Op    = 2'b00;
        mif.Mul   = 1'b1;
        mif.Funct = 6'd0;
        mif.Rd    = 4'd2;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        checkOutput("rst.pre_busy", 32'(mif.MulBusy), 32'd1);
        rst_main = 1'b0;
        #1;
        checkOutput("rst.enables", 32'({mif.IRWrite, mif.PCWrite, mif.RegWrite, mif.MemWrite}), 32'd0);
        checkOutput("rst.flags", 32'(mif.Flags), 32'd0);
        checkOutput("rst.busy", 32'(mif.MulBusy), 32'd0);
        checkOutput("rst.selects", 32'({mif.AdrSrc, mif.ALUSrcA, mif.ALUSrcB, mif.ResultSrc}), 32'(6'b011010));
        @(posedge clk);
        #1;
        checkOutput("rst.enables_hold", 32'({mif.IRWrite, mif.PCWrite, mif.RegWrite, mif.MemWrite}), 32'd0);
        @(negedge clk);
        rst_main    = 1'b1;
        model_flags = 4'b0000;
        #1;
        checkOutput("rst.first_fetch", 32'(mif.IRWrite), 32'd1);
    endtask

    task automatic measureMul(input int sel, input int lat);
        int         busy = 0;
        bit         done = 0;
        logic [3:0] o;
        rst_mul = 1'b0;
        @(negedge clk);
        rst_mul = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            o = (sel == 1) ? obs1 : obs7;
            if (o[3]) begin
                busy++;
            end else if (busy > 0) begin
                checkOutput($sformatf("mul%0d.mulwb", lat), 32'(o[2:0]), 32'(3'b111));
                done = 1;
            end
            @(negedge clk);
        end
        checkOutput($sformatf("mul%0d.busy_cycles", lat), 32'(busy), 32'(lat));
        checkOutput($sformatf("mul%0d.completed", lat), 32'(done), 32'd1);
    endtask

    initial begin
        logic [3:0] cond, rd;
        logic [1:0] op;
        logic [5:0] funct;
        logic       mul;
        rst_main    = 1'b0;
        rst_mul     = 1'b0;
        model_flags = 4'b0000;
        mif.Cond = AL; mif.Op = 2'b00; mif.Funct = 6'd0; mif.Rd = 4'd0; mif.Mul = 1'b0; mif.ALUFlags = 4'd0;
        mif1.Cond = AL; mif1.Op = 2'b00; mif1.Funct = 6'd0; mif1.Rd = 4'd4; mif1.Mul = 1'b1; mif1.ALUFlags = 4'd0;
        mif7.Cond = AL; mif7.Op = 2'b00; mif7.Funct = 6'd0; mif7.Rd = 4'd4; mif7.Mul = 1'b1; mif7.ALUFlags = 4'd0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset.enables", 32'({mif.IRWrite, mif.PCWrite, mif.RegWrite, mif.MemWrite}), 32'd0);
        checkOutput("reset.flags", 32'(mif.Flags), 32'd0);
        @(negedge clk);
        rst_main = 1'b1;

        applyStimulus(AL,    2'b00, 6'b001001, 4'd3,  1'b0, 4'b0100, "adds");
        applyStimulus(4'h0,  2'b10, 6'b000000, 4'd0,  1'b0, 4'b0000, "beq");
        applyStimulus(4'h1,  2'b10, 6'b000000, 4'd0,  1'b0, 4'b0000, "bne");
        applyStimulus(AL,    2'b01, 6'b011001, 4'd15, 1'b0, 4'b0000, "ldr_pc");
        applyStimulus(AL,    2'b01, 6'b011000, 4'd4,  1'b0, 4'b0000, "str");
        applyStimulus(AL,    2'b00, 6'b110100, 4'd5,  1'b0, 4'b1001, "cmp_imm");
        applyStimulus(AL,    2'b00, 6'b010000, 4'd5,  1'b0, 4'b0110, "tst");
        applyStimulus(AL,    2'b00, 6'b000000, 4'd6,  1'b1, 4'b0000, "mul");
        applyStimulus(4'hF,  2'b00, 6'b001000, 4'd7,  1'b0, 4'b1111, "nv");
        applyStimulus(AL,    2'b00, 6'b011010, 4'd15, 1'b0, 4'b1010, "mov_pc");
        applyStimulus(AL,    2'b00, 6'b001001, 4'd1,  1'b0, 4'b1111, "adds_all");
        resetMidMul();

        for (int i = 0; i < 150; i++) begin
            cond  = ($urandom_range(0, 1) == 0) ? AL : 4'($urandom);
            op    = 2'($urandom);
            funct = 6'($urandom);
            rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            mul   = (op == 2'b00) && ($urandom_range(0, 2) == 0);
            applyStimulus(cond, op, funct, rd, mul, 4'($urandom), $sformatf("rnd%0d", i));
        end

        measureMul(1, 1);
        measureMul(7, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised next-generation control unit for the multicycle ARM core. It merges the main FSM, the ALU/instruction decoders and a new condition unit with an internal NZCV flag register. It adds a variable-latency MUL state, an extended data-processing set and an early abort of failed-condition instructions in DECODE. It sits between the instruction register and the shared datapath, replacing the previous decoder plus FSM pair.

## Interface
- `ALUCTRL_W`, 3: ALUControl width; must be ≥3.
- `MUL_LAT`, 4: cycles spent in MULEX; must be ≥1.
- `clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `Cond`  in  4  Instr[31:28].
- `Op`  in  2  Instr[27:26].
- `Funct`  in  6  Instr[25:20].
- `Rd`  in  4  Instr[15:12].
- `Mul`  in  1  Instr[7:4]==1001 with Op==00, pre-decoded by the datapath.
- `ALUFlags`  in  4  NZCV from the ALU.
- `PCWrite, RegWrite, MemWrite, IRWrite`  out  1 each  gated write enables.
- `AdrSrc, ALUSrcA`  out  1 each  mux selects.
- `ALUSrcB, ResultSrc`  out  2 each  mux selects. ResultSrc=11 selects the multiplier result.
- `ALUControl`  out  ALUCTRL_W  ALU operation.
- `ImmSrc, RegSrc`  out  2 each  immediate and register-source selects.
- `MulBusy`  out  1  high while in MULEX.
- `Flags`  out  4  current NZCV register.

## Operation
- **Reset.** Reset low forces state FETCH, Flags=0000 and the MUL counter to 0. While Reset is low, all write enables are forced to 0; selects hold their FETCH values.
- **Condition evaluation.**
  - CondEx is computed from Cond and Flags using the standard ARM table EQ..AL.
  - Cond=1111 evaluates as false.
- **FETCH:** IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU op ADD. Next state: DECODE.
- **DECODE:** ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - If !CondEx → FETCH.
  - Else Op=01 → MEMADR.
  - Else Op=10 → BRANCH.
  - Else Op=00 with Mul=1 → MULEX.
  - Else Op=00 with Funct[5]=0 → EXECR.
  - Else Op=00 with Funct[5]=1 → EXECI.
  - Else Op=11 → FETCH, with no writes.
- **MEMADR:** ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 → MEMRD, else → MEMWR.
- **MEMRD:** AdrSrc=1, ResultSrc=00 → MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1, and PCWrite=1 if Rd==15 → FETCH.
- **MEMWR:** AdrSrc=1, MemWrite=1 → FETCH.
- **EXECR / EXECI:** ALUSrcA=0, ALUSrcB=00 for EXECR or 01 for EXECI, ALUControl from cmd=Funct[4:1] → ALUWB.
  - ADD 0100 and CMN 1011 → ADD (000).
  - SUB 0010 and CMP 1010 → SUB (001).
  - AND 0000 and TST 1000 → AND (010).
  - ORR 1100 → ORR (011).
  - EOR 0001 → EOR (100).
  - MOV 1101 → PASSB (101).
  - Any other cmd → ADD with NoWrite=1 and no flag write.
- **Flag update at the EXEC clock edge.**
  - Arithmetic ops (ADD, SUB, CMP, CMN) write NZCV.
  - Logic ops (AND, ORR, EOR, MOV, TST) write NZ only; C and V are kept.
  - Normal ops write flags only when S (Funct[0]) = 1.
  - CMP, CMN and TST always write flags and set NoWrite=1.
- **ALUWB:** ResultSrc=00, RegWrite=!NoWrite, PCWrite=!NoWrite & (Rd==15) → FETCH.
- **MULEX:** MulBusy=1. The counter loads MUL_LAT-1 on entry and decrements each cycle. When the counter is 0 → MULWB.
- **MULWB:** ResultSrc=11, RegWrite=1 → FETCH. Flags are unaffected.
- **BRANCH:** ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=1 → FETCH.
- **Instruction decode:** ImmSrc=Op. RegSrc[0]=(Op==10). RegSrc[1]=(Op==01).

## Timing
- Outputs are Moore-style, decoded from the state register, except that RegWrite/PCWrite depend on the registered Rd and NoWrite.
- Instruction latency in cycles:
  - Condition-failed: 2.
  - Branch: 3.
  - STR: 4.
  - Data-processing: 4.
  - LDR: 5.
  - MUL: 3+MUL_LAT.
- Flags become visible in the cycle after EXEC, so a following instruction's DECODE sees them.
- An asynchronous Reset in any state, including mid-MULEX, returns the block to FETCH immediately. No write enable may glitch high during reset.

## Structure
- Package `multicycle_pkg`:
  - state enum (FETCH..MULWB);
  - ALU code constants;
  - cmd constants;
  - cond-code constants;
  - ResultSrc and ALUSrcB encodings.
- Sub-module `cond_unit`: a combinational CondEx table plus the Flags register with NZ/CV write enables.

## Test plan
- Reset low mid-MULEX with MUL_LAT=4 → state FETCH, Flags=0000, all write enables 0. First edge after release → IRWrite=1.
- ADDS, then BEQ with ALUFlags=0100 → Flags=0100 after EXEC. BEQ runs FETCH→DECODE→BRANCH with PCWrite=1 in BRANCH.
- BNE with Z=1 → DECODE→FETCH. PCWrite, RegWrite and MemWrite stay 0 for those 2 cycles.
- LDR to Rd=15 → 5 cycles; MEMWB asserts RegWrite=1 and PCWrite=1 with ResultSrc=01.
- CMP imm with ALUFlags=1001 → ALUControl=001, Flags=1001, ALUWB RegWrite=0. A following TST with ALUFlags=0110 → Flags=0101.
- MUL with MUL_LAT=1 and with MUL_LAT=7 → MulBusy high for exactly 1 and 7 cycles respectively, then MULWB with ResultSrc=11 and RegWrite=1.
